// File: rtl/int_entry_sequencer.sv
// int_entry_sequencer: interrupt entry/return sequencer placed downstream of the
// interrupt controller. It accepts a request at a write-back boundary, pushes
// {resume PC, interrupt number} onto an EPC stack and redirects fetch to the
// handler vector. On ERET it pops the stack, redirects to the saved PC and
// pulses Circular_ERET_In back to the controller.
// Optional feature macro: NESTED_INT_EN (defined = nesting up to DEPTH,
// undefined = a single level of interrupt, no nesting).
module int_entry_sequencer #(
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_3000,
    parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0020,
    parameter int          DEPTH         = 4,
    parameter int          GUARD_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        IntRequest,
    input  logic [1:0]  IntNum,
    input  logic        WB_valid,
    input  logic [31:0] WB_NOINT_NextPC,
    input  logic        ERET,
    output logic        IntEnable,
    output logic        IntTaken,
    output logic        RedirectValid,
    output logic [31:0] RedirectPC,
    output logic        Circular_ERET_In,
    output logic [1:0]  CurIntNum,
    output logic [3:0]  Depth,
    output logic        StrayEret
);

`ifdef NESTED_INT_EN
    localparam int EFF_DEPTH = DEPTH;
`else
    localparam int EFF_DEPTH = 1;
`endif
    localparam logic [3:0] EFF_DEPTH_W = 4'(EFF_DEPTH);
    localparam logic [7:0] GUARD_LOAD  = 8'(GUARD_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GUARD  = 2'd1,
        RUN    = 2'd2,
        RETURN = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  guard_cnt;
    logic [31:0] epc_mem [EFF_DEPTH];
    logic [1:0]  num_mem [EFF_DEPTH];

    logic        eret_seen;
    logic        accept;
    logic        eret_accept;
    logic [3:0]  top_idx;
    logic [3:0]  below_idx;
    logic [31:0] vector_pc;

    // Decoded enable, derived only from registered state and depth so it stays glitch-free.
    assign IntEnable = ((state == IDLE) || (state == RUN)) && (Depth < EFF_DEPTH_W);

    // Acceptance decisions and stack addressing for the current cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        eret_seen   = 1'b0;
        accept      = 1'b0;
        eret_accept = 1'b0;
        top_idx     = Depth - 4'd1;
        below_idx   = Depth - 4'd2;
        vector_pc   = VECTOR_BASE + VECTOR_STRIDE * {30'd0, IntNum};

        eret_seen   = ERET && WB_valid;
        // ERET has priority: a request arriving with an ERET stays pending upstream.
        accept      = IntEnable && IntRequest && WB_valid && !eret_seen;
        eret_accept = eret_seen && (Depth != 4'd0) && ((state == GUARD) || (state == RUN));
    end

    // Sequencer FSM, EPC stack and all registered outputs.
    always_ff @(posedge clk) begin
        if (!clr) begin
            // NOTE: the stack is cleared on reset so popped/unused entries never leak stale PCs; the loop is fine because the stack is tiny.
            state            <= IDLE;
            guard_cnt        <= 8'd0;
            IntTaken         <= 1'b0;
            RedirectValid    <= 1'b0;
            RedirectPC       <= 32'd0;
            Circular_ERET_In <= 1'b0;
            CurIntNum        <= 2'd0;
            Depth            <= 4'd0;
            StrayEret        <= 1'b0;
            for (int i = 0; i < EFF_DEPTH; i++) begin
                epc_mem[i] <= 32'd0;
                num_mem[i] <= 2'd0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            IntTaken         <= 1'b0;
            RedirectValid    <= 1'b0;
            Circular_ERET_In <= 1'b0;

            if (eret_seen && (Depth == 4'd0)) begin
                StrayEret <= 1'b1;
            end

            unique case (state)
                IDLE, RUN: begin
                    if (eret_accept) begin
                        RedirectPC       <= epc_mem[top_idx[2:0]];
                        RedirectValid    <= 1'b1;
                        Circular_ERET_In <= 1'b1;
                        Depth            <= top_idx;
                        CurIntNum        <= (Depth >= 4'd2) ? num_mem[below_idx[2:0]] : 2'd0;
                        state            <= RETURN;
                    end else if (accept) begin
                        epc_mem[Depth[2:0]] <= WB_NOINT_NextPC;
                        num_mem[Depth[2:0]] <= IntNum;
                        Depth               <= Depth + 4'd1;
                        CurIntNum           <= IntNum;
                        RedirectPC          <= vector_pc;
                        RedirectValid       <= 1'b1;
                        IntTaken            <= 1'b1;
                        guard_cnt           <= GUARD_LOAD;
                        state               <= GUARD;
                    end
                end
                GUARD: begin
                    if (eret_accept) begin
                        RedirectPC       <= epc_mem[top_idx[2:0]];
                        RedirectValid    <= 1'b1;
                        Circular_ERET_In <= 1'b1;
                        Depth            <= top_idx;
                        CurIntNum        <= (Depth >= 4'd2) ? num_mem[below_idx[2:0]] : 2'd0;
                        state            <= RETURN;
                    end else if (guard_cnt <= 8'd1) begin
                        guard_cnt <= 8'd0;
                        state     <= RUN;
                    end else begin
                        guard_cnt <= guard_cnt - 8'd1;
                    end
                end
                RETURN: begin
                    state <= (Depth == 4'd0) ? IDLE : RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_entry_sequencer.sv
// Directed bench for int_entry_sequencer. Expectations follow the default
// parameters (base 0x3000, stride 0x20, depth 4, guard 4 cycles) and adapt to
// whether NESTED_INT_EN is defined.
module tb_int_entry_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        IntRequest;
    logic [1:0]  IntNum;
    logic        WB_valid;
    logic [31:0] WB_NOINT_NextPC;
    logic        ERET;
    logic        IntEnable;
    logic        IntTaken;
    logic        RedirectValid;
    logic [31:0] RedirectPC;
    logic        Circular_ERET_In;
    logic [1:0]  CurIntNum;
    logic [3:0]  Depth;
    logic        StrayEret;

    int n_cmp = 0;
    int n_err = 0;

`ifdef NESTED_INT_EN
    localparam logic NESTED = 1'b1;
`else
    localparam logic NESTED = 1'b0;
`endif

    int_entry_sequencer dut (
        .clk              (clk),
        .clr              (clr),
        .IntRequest       (IntRequest),
        .IntNum           (IntNum),
        .WB_valid         (WB_valid),
        .WB_NOINT_NextPC  (WB_NOINT_NextPC),
        .ERET             (ERET),
        .IntEnable        (IntEnable),
        .IntTaken         (IntTaken),
        .RedirectValid    (RedirectValid),
        .RedirectPC       (RedirectPC),
        .Circular_ERET_In (Circular_ERET_In),
        .CurIntNum        (CurIntNum),
        .Depth            (Depth),
        .StrayEret        (StrayEret)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        IntRequest      = 1'b0;
        IntNum          = 2'd0;
        WB_valid        = 1'b0;
        WB_NOINT_NextPC = 32'd0;
        ERET            = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".int_enable"}, 32'(IntEnable), 32'd1);
        check({tag, ".int_taken"}, 32'(IntTaken), 32'd0);
        check({tag, ".redirect_valid"}, 32'(RedirectValid), 32'd0);
        check({tag, ".redirect_pc"}, RedirectPC, 32'd0);
        check({tag, ".eret_in"}, 32'(Circular_ERET_In), 32'd0);
        check({tag, ".cur_num"}, 32'(CurIntNum), 32'd0);
        check({tag, ".depth"}, 32'(Depth), 32'd0);
        check({tag, ".stray"}, 32'(StrayEret), 32'd0);
    endtask

    initial begin
        // Reset
        idle_inputs();
        clr = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        clr = 1'b1;
        tick();

        // Entry with IntNum=2 from NextPC 0x104
        IntRequest = 1'b1; IntNum = 2'd2; WB_valid = 1'b1; WB_NOINT_NextPC = 32'h0000_0104;
        tick();
        check("entry.int_taken", 32'(IntTaken), 32'd1);
        check("entry.redirect_valid", 32'(RedirectValid), 32'd1);
        check("entry.redirect_pc", RedirectPC, 32'h0000_3040);
        check("entry.depth", 32'(Depth), 32'd1);
        check("entry.cur_num", 32'(CurIntNum), 32'd2);
        check("entry.int_enable_n1", 32'(IntEnable), 32'd0);
        idle_inputs();
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("guard.int_enable_n%0d", i), 32'(IntEnable), 32'd0);
            check($sformatf("guard.pulse_n%0d", i), 32'({IntTaken, RedirectValid}), 32'd0);
        end
        tick();
        check("guard.int_enable_n5", 32'(IntEnable), 32'(NESTED));

        // ERET returns to 0x104
        ERET = 1'b1; WB_valid = 1'b1;
        tick();
        check("eret.redirect_pc", RedirectPC, 32'h0000_0104);
        check("eret.redirect_valid", 32'(RedirectValid), 32'd1);
        check("eret.eret_in", 32'(Circular_ERET_In), 32'd1);
        check("eret.depth", 32'(Depth), 32'd0);
        check("eret.cur_num", 32'(CurIntNum), 32'd0);
        check("eret.int_enable_return", 32'(IntEnable), 32'd0);
        idle_inputs();
        tick();
        check("eret.eret_in_drop", 32'(Circular_ERET_In), 32'd0);
        check("eret.int_enable_back", 32'(IntEnable), 32'd1);

        // Request without a retiring instruction is not taken
        IntRequest = 1'b1; IntNum = 2'd1; WB_valid = 1'b0;
        tick();
        check("nowb.int_taken", 32'(IntTaken), 32'd0);
        check("nowb.depth", 32'(Depth), 32'd0);

        // ERET with empty stack is stray
        idle_inputs();
        ERET = 1'b1; WB_valid = 1'b1;
        tick();
        check("stray.flag", 32'(StrayEret), 32'd1);
        check("stray.redirect_valid", 32'(RedirectValid), 32'd0);
        check("stray.eret_in", 32'(Circular_ERET_In), 32'd0);
        idle_inputs();
        tick();
        check("stray.sticky", 32'(StrayEret), 32'd1);

        // ERET and request together at depth 1: return first, entry after RETURN
        IntRequest = 1'b1; IntNum = 2'd1; WB_valid = 1'b1; WB_NOINT_NextPC = 32'h0000_0200;
        tick();
        check("prio.entry_pc", RedirectPC, 32'h0000_3020);
        idle_inputs();
        repeat (4) tick();
        ERET = 1'b1; WB_valid = 1'b1; IntRequest = 1'b1; IntNum = 2'd3; WB_NOINT_NextPC = 32'h0000_0300;
        tick();
        check("prio.eret_in", 32'(Circular_ERET_In), 32'd1);
        check("prio.redirect_pc", RedirectPC, 32'h0000_0200);
        check("prio.no_entry", 32'(IntTaken), 32'd0);
        check("prio.depth0", 32'(Depth), 32'd0);
        ERET = 1'b0;
        tick();
        check("prio.return_no_entry", 32'(IntTaken), 32'd0);
        check("prio.int_enable_back", 32'(IntEnable), 32'd1);
        tick();
        check("prio.late_entry", 32'(IntTaken), 32'd1);
        check("prio.late_pc", RedirectPC, 32'h0000_3060);
        check("prio.late_num", 32'(CurIntNum), 32'd3);
        idle_inputs();

        // Reset during GUARD abandons the entry
        clr = 1'b0;
        tick();
        check_reset_outputs("guard_reset");
        clr = 1'b1;
        tick();

        if (NESTED) begin
            // Four nested entries, a fifth refused, then LIFO returns
            for (int k = 0; k < 4; k++) begin
                IntRequest = 1'b1; IntNum = 2'(k); WB_valid = 1'b1;
                WB_NOINT_NextPC = 32'h0000_1000 + 32'(4 * k);
                tick();
                check($sformatf("nest%0d.int_taken", k), 32'(IntTaken), 32'd1);
                check($sformatf("nest%0d.depth", k), 32'(Depth), 32'(k + 1));
                check($sformatf("nest%0d.cur_num", k), 32'(CurIntNum), 32'(k));
                idle_inputs();
                repeat (4) tick();
            end
            check("nest.full_int_enable", 32'(IntEnable), 32'd0);
            IntRequest = 1'b1; IntNum = 2'd0; WB_valid = 1'b1;
            tick();
            check("nest.fifth_refused", 32'(IntTaken), 32'd0);
            check("nest.fifth_depth", 32'(Depth), 32'd4);
            idle_inputs();
            for (int k = 3; k >= 0; k--) begin
                ERET = 1'b1; WB_valid = 1'b1;
                tick();
                check($sformatf("pop%0d.pc", k), RedirectPC, 32'h0000_1000 + 32'(4 * k));
                check($sformatf("pop%0d.depth", k), 32'(Depth), 32'(k));
                check($sformatf("pop%0d.cur_num", k), 32'(CurIntNum), (k > 0) ? 32'(k - 1) : 32'd0);
                idle_inputs();
                tick();
            end
            check("nest.idle_enable", 32'(IntEnable), 32'd1);
        end else begin
            // Single level: a second request is never accepted
            IntRequest = 1'b1; IntNum = 2'd1; WB_valid = 1'b1; WB_NOINT_NextPC = 32'h0000_0500;
            tick();
            check("single.entry", 32'(IntTaken), 32'd1);
            IntNum = 2'd2; WB_NOINT_NextPC = 32'h0000_0600;
            for (int i = 0; i < 6; i++) begin
                tick();
                check($sformatf("single.no_nest%0d", i), 32'(IntTaken), 32'd0);
                check($sformatf("single.depth%0d", i), 32'(Depth), 32'd1);
                check($sformatf("single.int_enable%0d", i), 32'(IntEnable), 32'd0);
            end
            idle_inputs();
            ERET = 1'b1; WB_valid = 1'b1;
            tick();
            check("single.return_pc", RedirectPC, 32'h0000_0500);
            check("single.return_num", 32'(CurIntNum), 32'd0);
            idle_inputs();
            tick();
            check("single.idle_enable", 32'(IntEnable), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
